huff_stream_sequencer: RTL and testbench
========================================

// Module: huff_stream_sequencer
// PURPOSE
//  Controller that feeds HuffmanDecoderTop from a word-packed code stream.
//  Accepts up to WORD_W code bits per word, LSB-first, and slices them into 1-4 bit chunks on the decoder svalid/aready port.
//  Counts decoded symbols against a programmed total, forwards them, and signals job completion.
//  Sits between the stream DMA/word source and the decoder.
// PARAMETERS
//  WORD_W   32  width of input code word; also the max valid bits per word
//  CNT_W    16  width of symbol total/counter
//  TIMEOUT  64  idle cycles without dec_tvalid before error (used only with macro)
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-low reset (0 = reset)
//  start       in   1        pulse: begin job; honoured only in IDLE
//  abort       in   1        pulse: drop job, return to IDLE, no done
//  sym_total   in   CNT_W    symbols in job, sampled on start
//  word_valid  in   1        input word valid
//  word_data   in   WORD_W   code bits, bit 0 sent first
//  word_bits   in   6        valid bits in word_data, 0..WORD_W
//  word_ready  out  1        sequencer accepts a word
//  dec_svalid  out  1        chunk valid to decoder
//  dec_bits    out  4        chunk bits, LSB-first; unused upper bits 0
//  dec_len     out  3        chunk length 1..4
//  dec_aready  in   1        decoder accepts chunk
//  dec_tvalid  in   1        decoder symbol valid
//  dec_symbol  in   4        decoder symbol, signed
//  sym_valid   out  1        forwarded symbol valid, registered
//  sym_data    out  4        forwarded symbol, signed
//  sym_count   out  CNT_W    symbols decoded in current/last job
//  busy        out  1        job in progress (LOAD/SEND)
//  done        out  1        1-cycle completion pulse
//  err         out  1        sticky timeout error; cleared on start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; shift register, bits_left, sym_count, target 0.
//  FSM IDLE -> LOAD -> SEND -> (LOAD | DONE) -> IDLE.
//  IDLE: start: latch target=sym_total, clear sym_count/err; target==0 -> DONE, else LOAD.
//  LOAD: word_ready=1. On word_valid&word_ready, latch word_data/word_bits; bits!=0 -> SEND.
//    word_bits==0: word is consumed and discarded; stay in LOAD.
//  SEND: dec_svalid=1; dec_len=min(4,bits_left); dec_bits=shreg[len-1:0], zero-padded.
//    Transfer = dec_svalid&dec_aready at posedge: shreg>>=len, bits_left-=len; reaches 0 -> LOAD.
//    aready low: svalid, bits and len held stable, no shift.
//  Codes may straddle words; no symbol alignment assumed.
//  Counting (LOAD/SEND): dec_tvalid -> sym_count+1, sym_valid/sym_data next cycle.
//  The count reaching target goes to DONE from LOAD or SEND, discarding residual bits.
//  dec_tvalid in IDLE/DONE is ignored: not counted, not forwarded.
//  DONE: done=1 for one cycle, same cycle as the final sym_valid -> IDLE.
//    sym_count holds until the next start.
//  Simultaneous final tvalid + chunk transfer: the transfer completes; next state DONE.
//  start while busy: ignored. abort has priority over all events: next state IDLE, outputs
//    word_ready/dec_svalid drop next cycle, no done, sym_count held.
//  reset asserted mid-job: immediate return to reset state; a partially sent code is lost.
//  Decoder is not reset by this block; the system resets both together.
// CONFIGURATION
//  HUFF_SEQ_TIMEOUT_EN defined: a counter runs while busy and clears on each dec_tvalid.
//    Reaching TIMEOUT sets err=1 (sticky) and forces DONE, with a done pulse.
//  Undefined: no counter; err tied 0; TIMEOUT ignored.
// TESTING
//  1 start total=1; word 0x0 bits=1 -> dec_bits=0 dec_len=1; tvalid sym 0 -> sym_data=0, done, count=1.
//  2 total=1; word 0x1F2 bits=9 (sym -8) -> chunks (0x2,4),(0xF,4),(0x1,1); tvalid -8 -> done.
//  3 dec_aready low 3 cycles in SEND -> dec_svalid/bits/len stable; no bits lost after release.
//  4 total=16, all symbols -8..7 packed in 6-bit words -> chunks 4,2 per word; 16 sym_valid, done.
//  5 total=0 -> done one cycle after start; abort mid-SEND -> IDLE, no done; reset mid-job -> outputs 0.
//  6 Macro on, no tvalid for 64 cycles -> err=1 + done; start clears err. Macro off -> err stays 0.

Source files
------------

// File: rtl/huff_stream_sequencer_if.sv
// Handshake and status bundle between the Huffman stream sequencer and its
// word source, decoder and job controller.
`default_nettype none

interface huff_stream_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     sym_total;
  logic                 word_valid;
  logic [WORD_W-1:0]    word_data;
  logic [5:0]           word_bits;
  logic                 word_ready;
  logic                 dec_svalid;
  logic [3:0]           dec_bits;
  logic [2:0]           dec_len;
  logic                 dec_aready;
  logic                 dec_tvalid;
  logic signed [3:0]    dec_symbol;
  logic                 sym_valid;
  logic signed [3:0]    sym_data;
  logic [CNT_W-1:0]     sym_count;
  logic                 busy;
  logic                 done;
  logic                 err;

  // master: the sequencer itself
  modport master (
    input  start, abort, sym_total, word_valid, word_data, word_bits,
           dec_aready, dec_tvalid, dec_symbol,
    output word_ready, dec_svalid, dec_bits, dec_len,
           sym_valid, sym_data, sym_count, busy, done, err
  );

  // slave: word source, decoder and job controller around it
  modport slave (
    output start, abort, sym_total, word_valid, word_data, word_bits,
           dec_aready, dec_tvalid, dec_symbol,
    input  word_ready, dec_svalid, dec_bits, dec_len,
           sym_valid, sym_data, sym_count, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/huff_stream_sequencer.sv
// Slices LSB-first code words into 1-4 bit decoder chunks and counts decoded symbols per job.
// Optional idle watchdog: define HUFF_SEQ_TIMEOUT_EN.
`default_nettype none

module huff_stream_sequencer #(
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  huff_stream_sequencer_if.master     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_W-1:0]    shreg_q, shreg_d;
  logic [5:0]           bits_left_q, bits_left_d;
  logic [CNT_W-1:0]     sym_count_q, sym_count_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic                 sym_valid_q, sym_valid_d;
  logic signed [3:0]    sym_data_q, sym_data_d;

  logic                 w_busy;
  logic                 w_timeout;
  logic [5:0]           w_word_bits;
  logic [2:0]           w_len;
  logic [3:0]           w_mask;

  assign w_busy      = (state_q == S_LOAD) || (state_q == S_SEND);
  assign w_word_bits = (bus.word_bits > 6'(WORD_W)) ? 6'(WORD_W) : bus.word_bits;
  assign w_len       = (bits_left_q > 6'd4) ? 3'd4 : bits_left_q[2:0];
  assign w_mask      = 4'((5'd1 << w_len) - 5'd1);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    sym_count_d = sym_count_q;
    target_d    = target_q;
    sym_valid_d = 1'b0;
    sym_data_d  = sym_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          target_d    = bus.sym_total;
          sym_count_d = '0;
          state_d     = (bus.sym_total == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        // Zero-bit words are consumed but leave us waiting for real code bits
        if (bus.word_valid) begin
          shreg_d     = bus.word_data;
          bits_left_d = w_word_bits;
          if (w_word_bits != 6'd0) state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.dec_aready) begin
          shreg_d     = shreg_q >> w_len;
          bits_left_d = bits_left_q - {3'b000, w_len};
          if (bits_left_q == {3'b000, w_len}) state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The final symbol ends the job even if a chunk moves in the same cycle
    if (w_busy && bus.dec_tvalid) begin
      sym_count_d = sym_count_q + CNT_W'(1);
      sym_valid_d = 1'b1;
      sym_data_d  = bus.dec_symbol;
      if (sym_count_d == target_q) state_d = S_DONE;
    end

    if (w_timeout) state_d = S_DONE;

    if (bus.abort) begin
      state_d     = S_IDLE;
      sym_count_d = sym_count_q;
      target_d    = target_q;
      sym_valid_d = 1'b0;
      sym_data_d  = sym_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      sym_count_q <= '0;
      target_q    <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      sym_count_q <= sym_count_d;
      target_q    <= target_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
    end
  end

`ifdef HUFF_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Watchdog counts busy cycles since the last decoded symbol
  always_comb begin
    w_timeout = w_busy && !bus.dec_tvalid && (tmo_q == TW'(TIMEOUT - 1));
    tmo_d     = '0;
    if (w_busy && !bus.dec_tvalid && !w_timeout) tmo_d = tmo_q + TW'(1);
    err_d = err_q;
    if (bus.abort)                           err_d = err_q;
    else if (state_q == S_IDLE && bus.start) err_d = 1'b0;
    else if (w_timeout)                      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign w_timeout = 1'b0;
  // TIMEOUT only matters when the watchdog is built in
  assign bus.err   = (TIMEOUT < 0);
`endif

  assign bus.word_ready = (state_q == S_LOAD);
  assign bus.dec_svalid = (state_q == S_SEND);
  assign bus.dec_len    = (state_q == S_SEND) ? w_len : 3'd0;
  assign bus.dec_bits   = (state_q == S_SEND) ? (shreg_q[3:0] & w_mask) : 4'd0;
  assign bus.sym_valid  = sym_valid_q;
  assign bus.sym_data   = sym_data_q;
  assign bus.sym_count  = sym_count_q;
  assign bus.busy       = w_busy;
  assign bus.done       = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_huff_stream_sequencer.sv
// Testbench for huff_stream_sequencer: queue-based job/chunk model plus literal pins.
`default_nettype none

module tb_huff_stream_sequencer;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  huff_stream_sequencer_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  huff_stream_sequencer #(.WORD_W(WORD_W), .CNT_W(CNT_W), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [3:0] b;
    int         l;
  } chunk_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: job activity, expected chunk stream of the current word, pending symbol/done
  bit                m_active, m_done, m_symv;
  logic signed [3:0] m_symd;
  int                m_count, m_target;
  chunk_t            q[$];
  chunk_t            log_q[$];

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_symv = 0; m_symd = 0;
    m_count = 0; m_target = 0;
    q.delete();
  endfunction

  function automatic void push_word(logic [31:0] data, int bits);
    for (int o = 0; o < bits; o += 4) begin
      chunk_t c;
      c.l = (bits - o > 4) ? 4 : bits - o;
      c.b = 4'((data >> o) & ((32'd1 << c.l) - 32'd1));
      q.push_back(c);
    end
  endfunction

  task automatic clear_inputs();
    bus.start = 0; bus.abort = 0; bus.sym_total = '0;
    bus.word_valid = 0; bus.word_data = '0; bus.word_bits = '0;
    bus.dec_aready = 0; bus.dec_tvalid = 0; bus.dec_symbol = '0;
  endtask

  task automatic compare();
    chk("busy", bus.busy, m_active);
    chk("done", bus.done, m_done);
    chk("sym_valid", bus.sym_valid, m_symv);
    if (m_symv) chk("sym_data", bus.sym_data, m_symd);
    chk("sym_count", bus.sym_count, m_count);
    chk("word_ready", bus.word_ready, m_active && q.size() == 0);
    chk("dec_svalid", bus.dec_svalid, m_active && q.size() != 0);
    if (m_active && q.size() != 0) begin
      chk("dec_bits", bus.dec_bits, q[0].b);
      chk("dec_len", bus.dec_len, q[0].l);
    end
    chk("err", bus.err, 0);
  endtask

  // Apply this cycle's inputs to the model, then move to the next negedge
  task automatic advance();
    bit nd = 0;
    bit ns = 0;
    if (bus.abort) begin
      m_active = 0;
      q.delete();
    end else if (!m_active) begin
      if (bus.start && !m_done) begin
        m_target = int'(bus.sym_total);
        m_count  = 0;
        if (m_target == 0) nd = 1;
        else               m_active = 1;
      end
    end else begin
      if (q.size() != 0) begin
        if (bus.dec_aready) begin
          log_q.push_back(q[0]);
          void'(q.pop_front());
        end
      end else if (bus.word_valid) begin
        push_word(bus.word_data, int'(bus.word_bits));
      end
      if (bus.dec_tvalid) begin
        m_count++;
        ns = 1;
        m_symd = bus.dec_symbol;
        if (m_count == m_target) begin
          nd = 1;
          m_active = 0;
          q.delete();
        end
      end
    end
    m_done = nd;
    m_symv = ns;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    compare();
    advance();
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_word_ready"}, bus.word_ready, 0);
    chk({tag, "_dec_svalid"}, bus.dec_svalid, 0);
    chk({tag, "_dec_bits"}, bus.dec_bits, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_sym_valid"}, bus.sym_valid, 0);
    chk({tag, "_sym_count"}, bus.sym_count, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    int n;
    clear_inputs();
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single 1-bit code, symbol 0
    log_q.delete();
    bus.start = 1; bus.sym_total = 1; tick(); clear_inputs();
    bus.word_valid = 1; bus.word_data = 32'h0; bus.word_bits = 1; tick(); clear_inputs();
    bus.dec_aready = 1; tick(); clear_inputs();
    bus.dec_tvalid = 1; bus.dec_symbol = 4'sd0; tick(); clear_inputs();
    chk("t1_done", bus.done, 1);
    chk("t1_sym_data", bus.sym_data, 0);
    chk("t1_count", bus.sym_count, 1);
    chk("t1_nchunks", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t1_chunk_bits", log_q[0].b, 0);
      chk("t1_chunk_len", log_q[0].l, 1);
    end
    tick();

    // 9-bit word with decoder stall, then symbol -8
    log_q.delete();
    bus.start = 1; bus.sym_total = 1; tick(); clear_inputs();
    bus.word_valid = 1; bus.word_data = 32'h1F2; bus.word_bits = 9; tick(); clear_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_svalid", bus.dec_svalid, 1);
      chk("t3_stall_bits", bus.dec_bits, 4'h2);
      chk("t3_stall_len", bus.dec_len, 4);
      tick();
    end
    bus.dec_aready = 1;
    for (int i = 0; i < 3; i++) tick();
    clear_inputs();
    chk("t2_nchunks", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t2_c0", {log_q[0].b, 4'(log_q[0].l)}, {4'h2, 4'd4});
      chk("t2_c1", {log_q[1].b, 4'(log_q[1].l)}, {4'hF, 4'd4});
      chk("t2_c2", {log_q[2].b, 4'(log_q[2].l)}, {4'h1, 4'd1});
    end
    bus.dec_tvalid = 1; bus.dec_symbol = -4'sd8; tick(); clear_inputs();
    chk("t2_done", bus.done, 1);
    chk("t2_sym_data", bus.sym_data, -8);
    tick();

    // Sixteen 6-bit words, symbols -8..7
    log_q.delete();
    bus.start = 1; bus.sym_total = 16; tick(); clear_inputs();
    for (int s = 0; s < 16; s++) begin
      bus.word_valid = 1; bus.word_data = 32'((s * 37) & 6'h3F); bus.word_bits = 6;
      tick(); clear_inputs();
      bus.dec_aready = 1; tick(); tick(); clear_inputs();
      bus.dec_tvalid = 1; bus.dec_symbol = 4'(s - 8); tick(); clear_inputs();
    end
    chk("t4_done", bus.done, 1);
    chk("t4_count", bus.sym_count, 16);
    chk("t4_nchunks", log_q.size(), 32);
    if (log_q.size() == 32) begin
      chk("t4_w1_c0", {log_q[2].b, 4'(log_q[2].l)}, {4'h5, 4'd4});
      chk("t4_w1_c1", {log_q[3].b, 4'(log_q[3].l)}, {4'h2, 4'd2});
    end
    tick();

    // Empty job finishes one cycle after start
    bus.start = 1; bus.sym_total = 0; tick(); clear_inputs();
    chk("t5_zero_done", bus.done, 1);
    chk("t5_zero_busy", bus.busy, 0);
    tick();

    // Abort mid-SEND: no done, count held
    bus.start = 1; bus.sym_total = 5; tick(); clear_inputs();
    bus.word_valid = 1; bus.word_data = 32'hABCD; bus.word_bits = 16; tick(); clear_inputs();
    bus.dec_aready = 1; bus.dec_tvalid = 1; bus.dec_symbol = 4'sd3; tick(); clear_inputs();
    bus.abort = 1; tick(); clear_inputs();
    chk("t5_abort_busy", bus.busy, 0);
    chk("t5_abort_svalid", bus.dec_svalid, 0);
    chk("t5_abort_count", bus.sym_count, 1);
    for (int i = 0; i < 3; i++) tick();

    // Watchdog
`ifdef HUFF_SEQ_TIMEOUT_EN
    bus.start = 1; bus.sym_total = 5; tick(); clear_inputs();
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("t6_timeout_cycles", n, 64);
    chk("t6_err_set", bus.err, 1);
    @(posedge clk); @(negedge clk);
    chk("t6_err_sticky", bus.err, 1);
    bus.start = 1; bus.sym_total = 1;
    @(posedge clk); @(negedge clk);
    clear_inputs();
    chk("t6_err_cleared", bus.err, 0);
    bus.abort = 1;
    @(posedge clk); @(negedge clk);
    clear_inputs();
    model_reset();
    m_count = 0;
    @(posedge clk); @(negedge clk);
`else
    bus.start = 1; bus.sym_total = 5; tick(); clear_inputs();
    for (int i = 0; i < 70; i++) tick();
    chk("t6_err_off", bus.err, 0);
    bus.abort = 1; tick(); clear_inputs();
    n = 0;
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      clear_inputs();
      if (!m_active && !m_done && $urandom_range(0, 7) == 0) begin
        bus.start = 1;
        bus.sym_total = CNT_W'($urandom_range(0, 12));
      end
      bus.abort      = ($urandom_range(0, 299) == 0);
      bus.word_valid = $urandom_range(0, 1) == 1;
      bus.word_data  = $urandom;
      bus.word_bits  = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 32));
      bus.dec_aready = $urandom_range(0, 9) < 6;
      bus.dec_tvalid = m_active && !bus.abort && ($urandom_range(0, 3) == 0);
      bus.dec_symbol = 4'($urandom_range(0, 15));
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();

    // Reset mid-job
    bus.start = 1; bus.sym_total = 3; tick(); clear_inputs();
    bus.word_valid = 1; bus.word_data = 32'h55; bus.word_bits = 8; tick(); clear_inputs();
    bus.dec_tvalid = 1; bus.dec_symbol = 4'sd1; tick(); clear_inputs();
    reset = 1'b0;
    #1;
    check_all_zero("t5_midreset");
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
